vga_timing_gen: RTL and testbench

//  Produces the VGA raster timing for 640x480@60: pixel enable, scan coordinates and sync/blank.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_sync_delay.sv | 39 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and game-state encodings.
// Imported by the timing generator and the pixel-colour renderer.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_PIPE_DLY = 1;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    function automatic logic [CNT_W-1:0] cnt10(input int v);
        return CNT_W'(v);
    endfunction

    localparam logic [CNT_W-1:0] VGA_HS_START =
        cnt10(VGA_H_ACTIVE + VGA_H_FP);
    localparam logic [CNT_W-1:0] VGA_HS_END =
        cnt10(VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC);
    localparam logic [CNT_W-1:0] VGA_VS_START =
        cnt10(VGA_V_ACTIVE + VGA_V_FP);
    localparam logic [CNT_W-1:0] VGA_VS_END =
        cnt10(VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC);

    typedef enum logic [1:0] {
        S_RUNNING   = 2'd0,
        S_GAME_OVER = 2'd1,
        S_WIN       = 2'd2
    } game_state_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register that keeps {hs, vs, blank_n} in step
// with the renderer's colour pipeline.
module vga_sync_delay #(
    parameter int         DEPTH   = 1,
    parameter logic [2:0] RST_VAL = 3'b110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] d,
    output logic [2:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, en};
            assign q = d;
        end else begin : g_pipe
            logic [2:0] stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, scan coordinates, delayed
// sync/blank for the DAC and a vertical-blank frame tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIPE_DLY = VGA_PIPE_DLY
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active_pixels,
    output logic       frame_tick,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST =
        cnt10(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST =
        cnt10(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = cnt10(H_ACTIVE);
    localparam logic [9:0] V_VIS    = cnt10(V_ACTIVE);
    localparam logic [9:0] V_TICK   = cnt10(V_ACTIVE - 1);
    localparam logic [9:0] HS_START = cnt10(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   =
        cnt10(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = cnt10(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   =
        cnt10(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_raw;
    logic          vs_raw;
    logic [2:0]    sync_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            pix_en  <= 1'b0;
            VGA_CLK <= 1'b0;
        end else begin
            div     <= (div == DIV_LAST) ? '0 : div + DW'(1);
            pix_en  <= (div == DIV_LAST);
            VGA_CLK <= (div >= DIV_HALF);
        end
    end

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Vertical blank begins when the raster steps onto line V_ACTIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && h_wrap && (v_cnt == V_TICK);
            if (pix_en) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
                if (h_wrap) begin
                    v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
                end
            end
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

    assign active_pixels = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   ({hs_raw, vs_raw, active_pixels}),
        .q   (sync_dly)
    );

    assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_dly;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen: a default-timing build, a
// shrunken-raster build and a PIPE_DLY=0 / CLK_DIV=4 build.
module tb_vga_timing_gen;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic       d_pix_en, d_act, d_ft, d_vga_clk;
    logic       d_hs, d_vs, d_blank, d_sync_n;
    logic [9:0] d_x, d_y;

    logic       s_pix_en, s_act, s_ft, s_vga_clk;
    logic       s_hs, s_vs, s_blank, s_sync_n;
    logic [9:0] s_x, s_y;

    logic       f_pix_en, f_act, f_ft, f_vga_clk;
    logic       f_hs, f_vs, f_blank, f_sync_n;
    logic [9:0] f_x, f_y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (d_pix_en),
        .x             (d_x),
        .y             (d_y),
        .active_pixels (d_act),
        .frame_tick    (d_ft),
        .VGA_CLK       (d_vga_clk),
        .VGA_HS        (d_hs),
        .VGA_VS        (d_vs),
        .VGA_BLANK_N   (d_blank),
        .VGA_SYNC_N    (d_sync_n)
    );

    // 16x12 raster: hsync low x=10..12, vsync low y=8..9.
    vga_timing_gen #(
        .CLK_DIV (2), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3),
        .H_BP (3), .V_ACTIVE (6), .V_FP (2), .V_SYNC (2),
        .V_BP (2), .PIPE_DLY (1)
    ) u_small (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (s_pix_en),
        .x             (s_x),
        .y             (s_y),
        .active_pixels (s_act),
        .frame_tick    (s_ft),
        .VGA_CLK       (s_vga_clk),
        .VGA_HS        (s_hs),
        .VGA_VS        (s_vs),
        .VGA_BLANK_N   (s_blank),
        .VGA_SYNC_N    (s_sync_n)
    );

    vga_timing_gen #(
        .CLK_DIV (4), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3),
        .H_BP (3), .V_ACTIVE (6), .V_FP (2), .V_SYNC (2),
        .V_BP (2), .PIPE_DLY (0)
    ) u_fast (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (f_pix_en),
        .x             (f_x),
        .y             (f_y),
        .active_pixels (f_act),
        .frame_tick    (f_ft),
        .VGA_CLK       (f_vga_clk),
        .VGA_HS        (f_hs),
        .VGA_VS        (f_vs),
        .VGA_BLANK_N   (f_blank),
        .VGA_SYNC_N    (f_sync_n)
    );

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pix(input int sel, output int n);
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if ((sel == 0 && d_pix_en) || (sel == 1 && s_pix_en) ||
                (sel == 2 && f_pix_en)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] v;
        int n;
        int hi;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd0) begin
            errors++;
            $display("FAIL rst_xy got %0d,%0d want 0,0", d_x, d_y);
        end
        v = {d_pix_en, d_vga_clk, d_hs, d_vs, d_blank, d_ft, d_sync_n};
        checks++;
        if (v !== 7'b0011000) begin
            errors++;
            $display("FAIL rst_def got %b want 0011000", v);
        end
        v = {s_pix_en, s_vga_clk, s_hs, s_vs, s_blank, s_ft, s_sync_n};
        checks++;
        if (v !== 7'b0011000 || s_x !== 10'd0 || s_y !== 10'd0) begin
            errors++;
            $display("FAIL rst_small got %b want 0011000", v);
        end
        v = {f_pix_en, f_vga_clk, f_hs, f_vs, f_blank, f_ft, f_sync_n};
        checks++;
        if (v !== 7'b0011100 || f_x !== 10'd0 || f_y !== 10'd0) begin
            errors++;
            $display("FAIL rst_fast got %b want 0011100", v);
        end
        rst = 1'b0;
        wait_pix(0, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL first_pix got %0d clk want 2", n);
        end
        wait_pix(0, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL pix_period got %0d clk want 2", n);
        end
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d_vga_clk) hi++;
        end
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL vga_clk_duty got %0d of 8 want 4", hi);
        end
    endtask

    task automatic test_line();
        int n, to, seq_bad, hs_bad, hs_low, first_low;
        logic exp_hs;
        to = 0; seq_bad = 0; hs_bad = 0; hs_low = 0; first_low = -1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            wait_pix(0, n);
            if (n == 0) to++;
            if (d_x !== 10'(i) || d_y !== 10'd0) seq_bad++;
            exp_hs = !((i - 1) >= 656 && (i - 1) < 752);
            if (d_hs !== exp_hs) hs_bad++;
            if (d_hs === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = i;
            end
        end
        wait_pix(0, n);
        checks++;
        if (to !== 0 || n == 0) begin
            errors++;
            $display("FAIL line_timeout got %0d want 0", to);
        end
        checks++;
        if (seq_bad !== 0) begin
            errors++;
            $display("FAIL line_seq got %0d bad want 0", seq_bad);
        end
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap got %0d,%0d want 0,1", d_x, d_y);
        end
        checks++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL hs_width got %0d want 96", hs_low);
        end
        checks++;
        if (first_low !== 657 || hs_bad !== 0) begin
            errors++;
            $display("FAIL hs_lag got start %0d bad %0d want 657 0",
                     first_low, hs_bad);
        end
    endtask

    task automatic test_frame();
        int ex, ey, py, pix, ft_cnt, ft_bad, seq_bad;
        int act, vs_low, vs_bad, blank_cnt;
        logic exp_vs;
        ex = 0; ey = 0; py = -1; pix = 0; ft_cnt = 0; ft_bad = 0;
        seq_bad = 0; act = 0; vs_low = 0; vs_bad = 0; blank_cnt = 0;
        do_reset();
        for (int c = 0; c < 386; c++) begin
            @(negedge clk);
            if (s_ft) begin
                ft_cnt++;
                if (s_x !== 10'd0 || s_y !== 10'd6) ft_bad++;
            end
            if (s_pix_en) begin
                if (s_x !== 10'(ex) || s_y !== 10'(ey)) seq_bad++;
                if (pix < 192) begin
                    if (s_act) act++;
                    if (s_blank) blank_cnt++;
                    if (!s_vs) vs_low++;
                end
                exp_vs = !(py == 8 || py == 9);
                if (s_vs !== exp_vs) vs_bad++;
                py = ey;
                pix++;
                ex = (ex == 15) ? 0 : ex + 1;
                if (ex == 0) ey = (ey == 11) ? 0 : ey + 1;
            end
        end
        checks++;
        if (pix !== 193 || seq_bad !== 0) begin
            errors++;
            $display("FAIL frame_seq got %0d pix %0d bad want 193 0",
                     pix, seq_bad);
        end
        checks++;
        if (act !== 48 || blank_cnt !== 48) begin
            errors++;
            $display("FAIL active got %0d blank %0d want 48 48",
                     act, blank_cnt);
        end
        checks++;
        if (vs_low !== 32 || vs_bad !== 0) begin
            errors++;
            $display("FAIL vsync got low %0d bad %0d want 32 0",
                     vs_low, vs_bad);
        end
        checks++;
        if (ft_cnt !== 1 || ft_bad !== 0) begin
            errors++;
            $display("FAIL frame_tick got %0d pulses %0d bad want 1 0",
                     ft_cnt, ft_bad);
        end
    endtask

    task automatic test_tick_spacing();
        int t [3];
        int got, bad;
        got = 0; bad = 0;
        for (int c = 0; c < 1300 && got < 3; c++) begin
            @(negedge clk);
            if (s_ft) begin
                t[got] = c;
                got++;
                if (s_x !== 10'd0 || s_y !== 10'd6) bad++;
            end
        end
        checks++;
        if (got !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL tick_count got %0d bad %0d want 3 0", got, bad);
        end else begin
            checks++;
            if (t[1] - t[0] !== 384 || t[2] - t[1] !== 384) begin
                errors++;
                $display("FAIL tick_spacing got %0d,%0d want 384",
                         t[1] - t[0], t[2] - t[1]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n, hit, bad;
        hit = 0; bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (s_x == 10'd5 && s_y == 10'd3) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (hit !== 1) begin
            errors++;
            $display("FAIL midrst_reach got %0d want 1", hit);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'd0 || s_blank !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got %0d,%0d want 0,0", s_x, s_y);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({s_x, s_y} !== 20'd0 || {s_hs, s_vs, s_blank} !== 3'b110)
                bad++;
            if ({d_x, d_y} !== 20'd0 || {d_hs, d_vs, d_blank} !== 3'b110)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_hold got %0d bad want 0", bad);
        end
        rst = 1'b0;
        wait_pix(1, n);
        checks++;
        if (n !== 2 || s_x !== 10'd0 || s_y !== 10'd0) begin
            errors++;
            $display("FAIL midrst_restart got %0d clk at %0d,%0d want 2 0,0",
                     n, s_x, s_y);
        end
        wait_pix(1, n);
        checks++;
        if (s_x !== 10'd1 || s_y !== 10'd0) begin
            errors++;
            $display("FAIL midrst_next got %0d,%0d want 1,0", s_x, s_y);
        end
    endtask

    task automatic test_div4();
        int n, hi, win_bad, bl_bad, act, to;
        win_bad = 0; bl_bad = 0; act = 0; to = 0;
        do_reset();
        wait_pix(2, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL div4_first got %0d clk want 4", n);
        end
        wait_pix(2, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL div4_period got %0d clk want 4", n);
        end
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (f_vga_clk) hi++;
            end
            if (hi != 2) win_bad++;
        end
        checks++;
        if (win_bad !== 0) begin
            errors++;
            $display("FAIL div4_vga_clk got %0d bad windows want 0", win_bad);
        end
        do_reset();
        for (int p = 0; p < 192; p++) begin
            wait_pix(2, n);
            if (n == 0) to++;
            if (f_blank !== f_act) bl_bad++;
            if (f_act) act++;
        end
        checks++;
        if (bl_bad !== 0 || act !== 48 || to !== 0) begin
            errors++;
            $display("FAIL nodly_blank got bad %0d act %0d want 0 48",
                     bl_bad, act);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_tick_spacing();
        test_mid_reset();
        test_div4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
